// File: rtl/disp_share_arb.sv
// disp_share_arb: decides which of three requesters owns the shared 4-digit
// seven-segment display. Requester 0 is the urgent channel and preempts the
// others. Requesters 1 and 2 share the display round-robin. Each owner keeps
// the display for a minimum dwell, and a blank gap separates two owners.
`timescale 1ns/1ps
module disp_share_arb #(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES   = 2_500_000,
  parameter logic [15:0] IDLE_HEX     = 16'h0000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic [3:0]  dp0,
  input  logic [3:0]  dp1,
  input  logic [3:0]  dp2,
  output logic [2:0]  grant,
  output logic [3:0]  hex3,
  output logic [3:0]  hex2,
  output logic [3:0]  hex1,
  output logic [3:0]  hex0,
  output logic [3:0]  dp_out,
  output logic        busy
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       rr_ptr;
  logic [1:0]       owner;

  logic [1:0]       sel;
  logic [2:0]       own_hot;
  logic             dwell_done;
  logic             leave;
  logic [15:0]      own_data;
  logic [3:0]       own_dp;

  // One-hot mask of a requester index.
  function automatic logic [2:0] onehot(input logic [1:0] k);
    case (k)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  // Urgent requester first, otherwise the first normal requester starting at
  // rr_ptr. Requester 0 is already handled, so only the order of 1 and 2
  // depends on the pointer: pointer 2 scans 2,0,1; pointers 0 and 1 reach 1
  // before 2.
  function automatic logic [1:0] sel_fn(input logic [2:0] r, input logic [1:0] ptr);
    if (r[0])
      sel_fn = 2'd0;
    else if (ptr == 2'd2)
      sel_fn = r[2] ? 2'd2 : 2'd1;
    else
      sel_fn = r[1] ? 2'd1 : 2'd2;
  endfunction

  // Pointer moves past the owner that just left.
  function automatic logic [1:0] next_ptr(input logic [1:0] k);
    next_ptr = (k == 2'd2) ? 2'd0 : k + 2'd1;
  endfunction

  assign sel        = sel_fn(req, rr_ptr);
  assign dwell_done = (cnt == DWELL_LAST);
  assign busy       = (state != IDLE);

  // Route the current owner's digits and decimal points toward the display.
  always_comb begin
    own_data = data0;
    own_dp   = dp0;
    case (owner)
      2'd1: begin
        own_data = data1;
        own_dp   = dp1;
      end
      2'd2: begin
        own_data = data2;
        own_dp   = dp2;
      end
      default: ;
    endcase
  end

  // The owner gives up the display on release, on a satisfied dwell with a
  // competitor waiting, or on urgent preemption (never applies to requester 0).
  always_comb begin
    own_hot = onehot(owner);
    leave   = 1'b0;
    if (state == OWN)
      leave = ((req & own_hot) == 3'b000) ||
              (dwell_done && ((req & ~own_hot) != 3'b000)) ||
              ((owner != 2'd0) && req[0]);
  end

  // Ownership FSM with registered grant and display outputs; the display is
  // blank except while an owner stays in OWN, so the first OWN cycle and every
  // GAP cycle show IDLE_HEX with all decimal points off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= IDLE;
      grant                  <= 3'b000;
      {hex3, hex2, hex1, hex0} <= IDLE_HEX;
      dp_out                 <= 4'b1111;
      cnt                    <= '0;
      rr_ptr                 <= 2'd1;
      owner                  <= 2'd0;
    end else begin
      {hex3, hex2, hex1, hex0} <= IDLE_HEX;
      dp_out                 <= 4'b1111;
      case (state)
        IDLE: begin
          if (req != 3'b000) begin
            owner <= sel;
            grant <= onehot(sel);
            cnt   <= '0;
            state <= OWN;
          end
        end
        OWN: begin
          if (leave) begin
            state  <= GAP;
            grant  <= 3'b000;
            cnt    <= '0;
            rr_ptr <= next_ptr(owner);
          end else begin
            {hex3, hex2, hex1, hex0} <= own_data;
            dp_out <= own_dp;
            if (!dwell_done)
              cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (req != 3'b000) begin
              owner <= sel;
              grant <= onehot(sel);
              state <= OWN;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 3'b000;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_share_arb.sv
// Directed testbench for disp_share_arb with DWELL_CYCLES=8, GAP_CYCLES=2.
`timescale 1ns/1ps
module tb_disp_share_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [15:0] data0 = 16'h0000, data1 = 16'h0000, data2 = 16'h0000;
  logic [3:0]  dp0 = 4'b1111, dp1 = 4'b1111, dp2 = 4'b1111;
  logic [2:0]  grant;
  logic [3:0]  hex3, hex2, hex1, hex0;
  logic [3:0]  dp_out;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  disp_share_arb #(
    .DWELL_CYCLES(8),
    .GAP_CYCLES(2),
    .IDLE_HEX(16'h0000),
    .CNT_W(26)
  ) dut (
    .clk(clk), .reset(reset), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .dp0(dp0), .dp1(dp1), .dp2(dp2),
    .grant(grant), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .dp_out(dp_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req   = 3'b000;
    tick();
    tick();
    n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL reset_grant: got %b want 000", grant); end
    n_cmp++; if ({hex3, hex2, hex1, hex0} !== 16'h0000) begin n_bad++; $display("FAIL reset_hex: got %h want 0000", {hex3, hex2, hex1, hex0}); end
    n_cmp++; if (dp_out !== 4'b1111) begin n_bad++; $display("FAIL reset_dp: got %b want 1111", dp_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    tick();
    n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL idle_grant: got %b want 000", grant); end
  endtask

  // Grant, one-cycle display latency, then early release at OWN cycle 3.
  task automatic test_basic_and_release;
    data1 = 16'h1234;
    dp1   = 4'b1011;
    req   = 3'b010;
    tick();
    n_cmp++; if (grant !== 3'b010) begin n_bad++; $display("FAIL basic_grant: got %b want 010", grant); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    n_cmp++; if ({hex3, hex2, hex1, hex0} !== 16'h0000) begin n_bad++; $display("FAIL basic_first_blank: got %h want 0000", {hex3, hex2, hex1, hex0}); end
    n_cmp++; if (dp_out !== 4'b1111) begin n_bad++; $display("FAIL basic_first_dp: got %b want 1111", dp_out); end
    tick();
    n_cmp++; if ({hex3, hex2, hex1, hex0} !== 16'h1234) begin n_bad++; $display("FAIL basic_hex: got %h want 1234", {hex3, hex2, hex1, hex0}); end
    n_cmp++; if (dp_out !== 4'b1011) begin n_bad++; $display("FAIL basic_dp: got %b want 1011", dp_out); end
    tick();
    tick();
    req = 3'b000;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (grant !== 3'b000 || busy !== 1'b1) begin n_bad++; $display("FAIL release_gap%0d: got grant=%b busy=%b want 000/1", i, grant, busy); end
      n_cmp++; if ({hex3, hex2, hex1, hex0, dp_out} !== 20'h0000F) begin n_bad++; $display("FAIL release_gap_blank%0d: got %h want 0000f", i, {hex3, hex2, hex1, hex0, dp_out}); end
    end
    tick();
    n_cmp++; if (grant !== 3'b000 || busy !== 1'b0 || dp_out !== 4'b1111) begin n_bad++; $display("FAIL release_idle: got grant=%b busy=%b dp=%b want 000/0/1111", grant, busy, dp_out); end
  endtask

  // Competitor arriving early must wait out the full dwell.
  task automatic test_dwell_hold;
    data2 = 16'hBEEF;
    dp2   = 4'b0111;
    req   = 3'b010;
    tick();
    tick();
    tick();
    req = 3'b110;
    for (int i = 3; i < 8; i++) begin
      tick();
      n_cmp++; if (grant !== 3'b010) begin n_bad++; $display("FAIL dwell_hold_c%0d: got %b want 010", i, grant); end
    end
    n_cmp++; if ({hex3, hex2, hex1, hex0} !== 16'h1234) begin n_bad++; $display("FAIL dwell_hex: got %h want 1234", {hex3, hex2, hex1, hex0}); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (grant !== 3'b000 || {hex3, hex2, hex1, hex0, dp_out} !== 20'h0000F) begin n_bad++; $display("FAIL dwell_gap%0d: got grant=%b disp=%h want 000/0000f", i, grant, {hex3, hex2, hex1, hex0, dp_out}); end
    end
    tick();
    n_cmp++; if (grant !== 3'b100) begin n_bad++; $display("FAIL dwell_handover: got %b want 100", grant); end
  endtask

  // Both normal requesters held: 8-cycle turns alternating through gaps.
  task automatic test_round_robin;
    logic [2:0] cur;
    logic [2:0] nxt;
    logic [15:0] want_hex;
    for (int r = 0; r < 2; r++) begin
      cur      = (r == 0) ? 3'b100 : 3'b010;
      nxt      = (r == 0) ? 3'b010 : 3'b100;
      want_hex = (r == 0) ? 16'hBEEF : 16'h1234;
      for (int i = 1; i < 8; i++) begin
        tick();
        n_cmp++; if (grant !== cur) begin n_bad++; $display("FAIL rr_own_r%0d_c%0d: got %b want %b", r, i, grant, cur); end
        if (i == 4) begin
          n_cmp++; if ({hex3, hex2, hex1, hex0} !== want_hex) begin n_bad++; $display("FAIL rr_hex_r%0d: got %h want %h", r, {hex3, hex2, hex1, hex0}, want_hex); end
        end
      end
      tick();
      n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL rr_gap0_r%0d: got %b want 000", r, grant); end
      tick();
      n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL rr_gap1_r%0d: got %b want 000", r, grant); end
      tick();
      n_cmp++; if (grant !== nxt) begin n_bad++; $display("FAIL rr_next_r%0d: got %b want %b", r, grant, nxt); end
    end
    req = 3'b000;
    tick();
    tick();
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rr_to_idle: got busy=%b want 0", busy); end
  endtask

  // Urgent requester preempts owner 2 without waiting for dwell.
  task automatic test_preempt;
    data0 = 16'hA5C3;
    dp0   = 4'b0110;
    req   = 3'b100;
    tick();
    n_cmp++; if (grant !== 3'b100) begin n_bad++; $display("FAIL pre_owner2: got %b want 100", grant); end
    tick();
    req = 3'b101;
    tick();
    n_cmp++; if (grant !== 3'b000 || {hex3, hex2, hex1, hex0} !== 16'h0000) begin n_bad++; $display("FAIL pre_gap: got grant=%b hex=%h want 000/0000", grant, {hex3, hex2, hex1, hex0}); end
    tick();
    tick();
    n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL pre_urgent: got %b want 001", grant); end
    tick();
    n_cmp++; if ({hex3, hex2, hex1, hex0} !== 16'hA5C3 || dp_out !== 4'b0110) begin n_bad++; $display("FAIL pre_urgent_disp: got %h/%b want a5c3/0110", {hex3, hex2, hex1, hex0}, dp_out); end
    req = 3'b100;
    tick();
    n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL pre_release_gap: got %b want 000", grant); end
    tick();
    tick();
    n_cmp++; if (grant !== 3'b100) begin n_bad++; $display("FAIL pre_return: got %b want 100", grant); end
    tick();
    n_cmp++; if ({hex3, hex2, hex1, hex0} !== 16'hBEEF || dp_out !== 4'b0111) begin n_bad++; $display("FAIL pre_return_disp: got %h/%b want beef/0111", {hex3, hex2, hex1, hex0}, dp_out); end
  endtask

  // Reset asserted between edges clears everything at once.
  task automatic test_async_reset;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (grant !== 3'b000 || busy !== 1'b0) begin n_bad++; $display("FAIL areset_ctrl: got grant=%b busy=%b want 000/0", grant, busy); end
    n_cmp++; if ({hex3, hex2, hex1, hex0, dp_out} !== 20'h0000F) begin n_bad++; $display("FAIL areset_disp: got %h want 0000f", {hex3, hex2, hex1, hex0, dp_out}); end
    #2;
    reset = 1'b0;
    tick();
    n_cmp++; if (grant !== 3'b100) begin n_bad++; $display("FAIL areset_regrant: got %b want 100", grant); end
  endtask

  // A sole owner past its dwell keeps the display; urgent wins from idle.
  task automatic test_hold_and_urgent_sel;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_cmp++; if (grant !== 3'b100) begin n_bad++; $display("FAIL hold_c%0d: got %b want 100", i, grant); end
    end
    req = 3'b000;
    tick();
    tick();
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hold_idle: got busy=%b want 0", busy); end
    req = 3'b111;
    tick();
    n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL urgent_sel: got %b want 001", grant); end
  endtask

  initial begin
    test_reset();
    test_basic_and_release();
    test_dwell_hold();
    test_round_robin();
    test_preempt();
    test_async_reset();
    test_hold_and_urgent_sel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
